// File: rtl/alu_sched_pkg.sv
// Shared FSM state type and opcode constants for the alu_sched scheduler.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_e;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_INC  = 2;
    localparam int OP_DEC  = 3;
    localparam int OP_LAST = 3;

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after last_grant wins.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    int              cand;
    logic [ID_W-1:0] idx;
    logic            found;

    // NOTE: every variable gets a default before the search so no path infers a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        idx       = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = int'(last_grant) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            idx = ID_W'(cand);
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one registered ALU between NUM_REQ requesters.
// Define ALU_SCHED_OPCHK_EN to reject opcodes above OP_LAST with rsp_err instead of issuing them.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int OPCODE_WIDTH = 2,
    parameter  int DATA_WIDTH   = 127,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*(OPCODE_WIDTH+1)-1:0] req_opcode,
    input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0]   req_op1,
    input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0]   req_op2,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [ID_W-1:0]                     rsp_id,
    output logic [DATA_WIDTH:0]                 rsp_result,
    output logic                                rsp_carry,
    output logic                                rsp_zero,
    output logic                                rsp_err,
    output logic                                busy,
    output logic [OPCODE_WIDTH:0]               alu_opcode,
    output logic [DATA_WIDTH:0]                 alu_op1,
    output logic [DATA_WIDTH:0]                 alu_op2,
    input  logic [DATA_WIDTH:0]                 alu_result,
    input  logic                                alu_carry,
    input  logic                                alu_zero
);

    state_e                state_q, state_d;
    logic [ID_W-1:0]       last_grant, grant_idx;
    logic [NUM_REQ-1:0]    grant;
    logic                  xfer;
    logic [OPCODE_WIDTH:0] sel_opcode;
    logic [DATA_WIDTH:0]   sel_op1, sel_op2;

    // Gating with rstn keeps req_ready low while reset is held, like every other output.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .en         ((state_q == IDLE) && rstn),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign req_ready  = grant;
    assign xfer       = |grant;
    assign busy       = (state_q != IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign sel_opcode = req_opcode[int'(grant_idx)*(OPCODE_WIDTH+1) +: OPCODE_WIDTH+1];
    assign sel_op1    = req_op1[int'(grant_idx)*(DATA_WIDTH+1) +: DATA_WIDTH+1];
    assign sel_op2    = req_op2[int'(grant_idx)*(DATA_WIDTH+1) +: DATA_WIDTH+1];

`ifdef ALU_SCHED_OPCHK_EN
    localparam logic [OPCODE_WIDTH:0] OPC_MAX = (OPCODE_WIDTH+1)'(OP_LAST);
    logic illegal;
    assign illegal = (sel_opcode > OPC_MAX);
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
`ifdef ALU_SCHED_OPCHK_EN
                    state_d = illegal ? RESP : ISSUE;
`else
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset to NUM_REQ-1 so requester 0 is first in line after any reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= ID_W'(NUM_REQ - 1);
            rsp_id     <= '0;
            alu_opcode <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
`ifdef ALU_SCHED_OPCHK_EN
            rsp_err    <= 1'b0;
`endif
        end else begin
            if (state_q == IDLE && xfer) begin
                last_grant <= grant_idx;
                rsp_id     <= grant_idx;
`ifdef ALU_SCHED_OPCHK_EN
                if (illegal) begin
                    rsp_result <= '0;
                    rsp_carry  <= 1'b0;
                    rsp_zero   <= 1'b0;
                    rsp_err    <= 1'b1;
                end else begin
                    alu_opcode <= sel_opcode;
                    alu_op1    <= sel_op1;
                    alu_op2    <= sel_op2;
                end
`else
                alu_opcode <= sel_opcode;
                alu_op1    <= sel_op1;
                alu_op2    <= sel_op2;
`endif
            end
            if (state_q == CAPTURE) begin
                rsp_result <= alu_result;
                rsp_carry  <= alu_carry;
                rsp_zero   <= alu_zero;
`ifdef ALU_SCHED_OPCHK_EN
                rsp_err    <= 1'b0;
`endif
            end
        end
    end

`ifndef ALU_SCHED_OPCHK_EN
    assign rsp_err = 1'b0;
`endif

endmodule
